syscall_unit: RTL and testbench
===============================

# syscall_unit

Responder for the CPU's syscall request: when the datapath decodes `syscall`, this block services the request using the $v0 service code and the $a0 argument that the register file presents on the syscall read ports. It supports three services: display, halt and pause-until-button. It owns the `SyscallOut` value and the `total_cycle` statistic that feed the seven-segment display path. It sits beside the register file in the CPU top, runs on the CPU run clock, and feeds stall/halt back to PC update.

## Interface
Parameters:
- `CODE_DISPLAY`, 34, $v0 value: latch $a0 for display
- `CODE_HALT`, 10, $v0 value: stop execution until reset
- `CODE_PAUSE`, 50, $v0 value: freeze until resume button

Ports:
- `clk`  in  1  CPU run clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `syscall_req`  in  1  controller `syscall` decode, high for the whole time the syscall instruction is at PC
- `v0`  in  32  register-file port A while `syscall_req` is high
- `a0`  in  32  register-file port B while `syscall_req` is high
- `resume`  in  1  raw push-button, asynchronous to `clk`
- `stall`  out  1  hold PC (Mealy output)
- `halt`  out  1  stop PC permanently (Mealy output)
- `syscall_out`  out  32  last displayed $a0
- `total_cycle`  out  32  executed-cycle count
- `syscall_count`  out  16  accepted syscalls

## Operation
- States: RUN, PAUSE, RELEASE, HALT. Reset state is RUN.
- Reset values: `syscall_out`=0, `total_cycle`=0, `syscall_count`=0, `stall`=0, `halt`=0, synchroniser flops=0.
- RUN, `syscall_req`=1 with `v0`==CODE_DISPLAY:
  - `syscall_out`<=`a0`
  - `syscall_count`++
  - stay in RUN; PC advances normally.
- RUN, `syscall_req`=1 with `v0`==CODE_HALT:
  - `halt`=1 combinationally in the same cycle, so PC holds on the syscall
  - `syscall_count`++
  - next state HALT.
- RUN, `syscall_req`=1 with `v0`==CODE_PAUSE:
  - `stall`=1 combinationally in the same cycle
  - `syscall_count`++
  - next state PAUSE.
- RUN, any other `v0` value: the syscall is ignored as a NOP; no count is taken.
- PAUSE:
  - `stall`=1
  - a rising edge on synchronised `resume` moves the state to RELEASE
  - `syscall_req` is ignored.
- RELEASE:
  - `stall`=0
  - `syscall_req` is masked, because the same pause instruction is still at PC
  - always moves to RUN on the next edge, which is the edge where PC steps past the syscall.
- HALT:
  - `halt`=1
  - `stall`=1
  - only `rst` leaves this state; `resume` is ignored.
- Outputs:
  - `stall` = (state==PAUSE) | (state==HALT) | (RUN & req & v0==CODE_PAUSE)
  - `halt` = (state==HALT) | (RUN & req & v0==CODE_HALT).
- Counting rules:
  - `total_cycle` increments in RUN and RELEASE; it saturates at 32'hFFFF_FFFF.
  - `syscall_count` wraps modulo 2^16.
- `v0` is compared on all 32 bits; upper bits must be zero for a match.

## Timing
- `resume` path: two-flop synchroniser, then rising-edge detect. Button-to-RELEASE latency is 3 `clk` edges.
- A resume edge detected while the state is not PAUSE is discarded, including an edge in the same cycle the pause is accepted. Each PAUSE needs a fresh press.
- `syscall_out` is updated at the accepting edge and is visible in the following cycle.
- Back-to-back display syscalls on consecutive cycles are each latched; the last one wins.
- A held `resume` level produces exactly one RELEASE.
- Reset asserted mid-PAUSE or mid-HALT: the state returns to RUN immediately, asynchronously, and all counters clear.

## Structure
- Shared package `syscall_pkg`:
  - state enum {RUN, PAUSE, RELEASE, HALT}
  - the three service-code constants, used by this block and by the controller or testbench.
- Sub-module `button_sync_edge`: two-flop synchroniser plus one-cycle rising-edge pulse; it is reused for the other board buttons.
- The top instantiates one `syscall_unit`:
  - drive `show_signal` `SyscallOut`/`total_cycle` from it
  - gate the PC load with ~(`stall`|`halt`).

## Test plan
- Reset, then `syscall_req`=1, `v0`=34, `a0`=32'h1234_5678 for 1 cycle -> next cycle `syscall_out`=32'h1234_5678, `syscall_count`=1, `stall`=0.
- `v0`=50 request held -> `stall`=1 the same cycle. Wait 10 cycles with `total_cycle` frozen, pulse `resume` -> RELEASE 3 edges later, `stall`=0, no re-pause, `syscall_count`=1.
- `v0`=10 -> `halt`=1 immediately and permanently. Press `resume` -> no change. Assert `rst`=0 -> `halt`=0, counters 0.
- Request with `v0`=7 -> no state change, `syscall_count` unchanged, `syscall_out` unchanged.
- `resume` pulse arriving in the same cycle the pause is accepted -> remains in PAUSE until a second press.
- Preload `total_cycle` near the top by forcing it, then run 5 cycles -> holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall responder: FSM states and the $v0
// service codes understood by the controller, this block and the bench.
package syscall_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSE   = 2'd1,
        RELEASE = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [31:0] SVC_DISPLAY = 32'd34;
    localparam logic [31:0] SVC_HALT    = 32'd10;
    localparam logic [31:0] SVC_PAUSE   = 32'd50;

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser for a raw board button followed by a one-cycle
// rising-edge pulse. A held button yields exactly one pulse.
module button_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronise the button and remember the previous synchronised level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= button;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/syscall_unit.sv
// Syscall responder: services display / halt / pause-until-button requests
// decoded by the controller, and keeps the display value, executed-cycle
// count and accepted-syscall count. stall/halt are Mealy so PC holds on the
// syscall in the very cycle it is decoded.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter logic [31:0] CODE_DISPLAY = SVC_DISPLAY,
    parameter logic [31:0] CODE_HALT    = SVC_HALT,
    parameter logic [31:0] CODE_PAUSE   = SVC_PAUSE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_req,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic        resume,
    output logic        stall,
    output logic        halt,
    output logic [31:0] syscall_out,
    output logic [31:0] total_cycle,
    output logic [15:0] syscall_count
);

    state_t      state;
    state_t      next_state;
    logic        resume_rise;
    logic        accept;
    logic        display;
    logic [31:0] cycle_q;
    logic [15:0] count_q;
    logic [31:0] out_q;

    button_sync_edge u_resume (
        .clk    (clk),
        .rst    (rst),
        .button (resume),
        .rise   (resume_rise)
    );

    // State register; reset drops straight back to RUN even mid-PAUSE/HALT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= next_state;
    end

    // Next state and Mealy stall/halt; a resume edge outside PAUSE is dropped
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        halt       = 1'b0;
        accept     = 1'b0;
        display    = 1'b0;
        case (state)
            RUN: begin
                if (syscall_req) begin
                    if (v0 == CODE_DISPLAY) begin
                        accept  = 1'b1;
                        display = 1'b1;
                    end else if (v0 == CODE_HALT) begin
                        accept     = 1'b1;
                        halt       = 1'b1;
                        next_state = HALT;
                    end else if (v0 == CODE_PAUSE) begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        next_state = PAUSE;
                    end
                end
            end
            PAUSE: begin
                stall = 1'b1;
                if (resume_rise) next_state = RELEASE;
            end
            // The pause syscall is still at PC here, so the request is masked
            RELEASE: next_state = RUN;
            HALT: begin
                stall = 1'b1;
                halt  = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    // Display latch, accepted-syscall counter (wraps) and cycle counter (saturates)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= 32'd0;
            count_q <= 16'd0;
            cycle_q <= 32'd0;
        end else begin
            if (display) out_q <= a0;
            if (accept)  count_q <= count_q + 16'd1;
            if ((state == RUN || state == RELEASE) && cycle_q != 32'hFFFF_FFFF)
                cycle_q <= cycle_q + 32'd1;
        end
    end

    assign syscall_out   = out_q;
    assign total_cycle   = cycle_q;
    assign syscall_count = count_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: display values go through a scoreboard
// queue, counters are tracked by a small reference model.
module tb_syscall_unit;
    import syscall_pkg::*;

    logic        clk;
    logic        rst;
    logic        syscall_req;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        resume;
    logic        stall;
    logic        halt;
    logic [31:0] syscall_out;
    logic [31:0] total_cycle;
    logic [15:0] syscall_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_out;
    logic [31:0] exp_tc;
    logic [15:0] exp_cnt;

    syscall_unit dut (
        .clk           (clk),
        .rst           (rst),
        .syscall_req   (syscall_req),
        .v0            (v0),
        .a0            (a0),
        .resume        (resume),
        .stall         (stall),
        .halt          (halt),
        .syscall_out   (syscall_out),
        .total_cycle   (total_cycle),
        .syscall_count (syscall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock edge; cnt says whether the state before the edge counts cycles
    task automatic cyc(input bit cnt);
        @(posedge clk);
        if (cnt && exp_tc != 32'hFFFF_FFFF) exp_tc = exp_tc + 32'd1;
        #1;
    endtask

    task automatic pop_out(input string tag);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s got=empty exp=entry", tag);
        end else begin
            exp_out = sb.pop_front();
            checks--;
            chk(tag, syscall_out, exp_out);
        end
    endtask

    task automatic disp(input logic [31:0] d);
        syscall_req = 1'b1;
        v0 = SVC_DISPLAY;
        a0 = d;
        sb.push_back(d);
        exp_cnt = exp_cnt + 16'd1;
        #1 chk("disp_stall", {31'd0, stall}, 32'd0);
        cyc(1);
        pop_out("disp_out");
        chk("disp_cnt", {16'd0, syscall_count}, {16'd0, exp_cnt});
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_tc"}, total_cycle, exp_tc);
        chk({tag, "_cnt"}, {16'd0, syscall_count}, {16'd0, exp_cnt});
        chk({tag, "_out"}, syscall_out, exp_out);
    endtask

    initial begin
        rst = 1'b0; syscall_req = 1'b0; v0 = '0; a0 = '0; resume = 1'b0;
        exp_out = '0; exp_tc = '0; exp_cnt = '0;
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk_counters("rst");
        @(negedge clk) rst = 1'b1;

        // Display, then back-to-back displays (last wins)
        disp(32'h1234_5678);
        syscall_req = 1'b0;
        #1 chk("after_disp_stall", {31'd0, stall}, 32'd0);
        cyc(1);
        disp(32'hAAAA_0001);
        disp(32'hBBBB_0002);
        syscall_req = 1'b0;
        cyc(1);
        chk_counters("b2b");

        // Unknown code and code with upper bits set are NOPs
        syscall_req = 1'b1; v0 = 32'd7; a0 = 32'hDEAD_BEEF;
        #1 chk("nop_stall", {30'd0, stall, halt}, 32'd0);
        cyc(1);
        v0 = 32'h8000_0022;
        #1 chk("hi_stall", {30'd0, stall, halt}, 32'd0);
        cyc(1);
        syscall_req = 1'b0;
        chk_counters("nop");

        // Pause, frozen cycles, single resume press
        syscall_req = 1'b1; v0 = SVC_PAUSE; a0 = '0;
        #1 chk("pause_mealy", {30'd0, stall, halt}, 32'd2);
        exp_cnt = exp_cnt + 16'd1;
        cyc(1);
        repeat (10) cyc(0);
        chk("pause_stall", {31'd0, stall}, 32'd1);
        chk_counters("pause_frozen");
        resume = 1'b1; cyc(0);
        resume = 1'b0; cyc(0);
        chk("pause_pre_rel", {31'd0, stall}, 32'd1);
        cyc(0);
        chk("release_mealy", {30'd0, stall, halt}, 32'd0);
        cyc(1);
        syscall_req = 1'b0;
        #1 chk("run_after_rel", {31'd0, stall}, 32'd0);
        cyc(1);
        chk_counters("pause_done");

        // Held resume level releases only once
        resume = 1'b1;
        repeat (3) cyc(1);
        syscall_req = 1'b1; v0 = SVC_PAUSE;
        exp_cnt = exp_cnt + 16'd1;
        cyc(1);
        repeat (5) cyc(0);
        chk("held_no_rel", {31'd0, stall}, 32'd1);
        resume = 1'b0;
        repeat (3) cyc(0);
        resume = 1'b1;
        repeat (3) cyc(0);
        chk("held_rel", {31'd0, stall}, 32'd0);
        cyc(1);
        syscall_req = 1'b0; resume = 1'b0;
        repeat (3) cyc(1);

        // Resume edge detected in the accepting cycle is discarded
        resume = 1'b1;
        cyc(1); cyc(1);
        syscall_req = 1'b1; v0 = SVC_PAUSE;
        #1 chk("coinc_mealy", {31'd0, stall}, 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        cyc(1);
        resume = 1'b0;
        repeat (6) cyc(0);
        chk("coinc_still_paused", {31'd0, stall}, 32'd1);
        resume = 1'b1; cyc(0);
        resume = 1'b0; cyc(0); cyc(0);
        chk("coinc_rel", {31'd0, stall}, 32'd0);
        cyc(1);
        syscall_req = 1'b0;
        cyc(1);
        chk_counters("coinc");

        // Halt: immediate, permanent, resume ignored, reset clears
        syscall_req = 1'b1; v0 = SVC_HALT;
        #1 chk("halt_mealy", {30'd0, stall, halt}, 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        cyc(1);
        chk("halt_state", {30'd0, stall, halt}, 32'd3);
        resume = 1'b1;
        repeat (5) cyc(0);
        resume = 1'b0;
        cyc(0);
        syscall_req = 1'b0;
        #1 chk("halt_hold", {30'd0, stall, halt}, 32'd3);
        chk_counters("halt");
        rst = 1'b0;
        sb.delete();
        exp_out = '0; exp_tc = '0; exp_cnt = '0;
        #1 chk("rst_halt_out", {30'd0, stall, halt}, 32'd0);
        chk_counters("rst_mid");
        @(negedge clk) rst = 1'b1;

        // Cycle counter saturation
        cyc(1);
        force dut.cycle_q = 32'hFFFF_FFFD;
        #1 release dut.cycle_q;
        exp_tc = 32'hFFFF_FFFD;
        repeat (5) cyc(1);
        chk("tc_sat", total_cycle, 32'hFFFF_FFFF);

        // Syscall counter wrap
        force dut.count_q = 16'hFFFF;
        #1 release dut.count_q;
        exp_cnt = 16'hFFFF;
        disp(32'h0000_0055);
        syscall_req = 1'b0;
        chk("cnt_wrap", {16'd0, syscall_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
